// File: rtl/axi_lite_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_master_if
//  Purpose  : 128-bit AXI-Lite-style channel bundle between one master and
//             one slave. It carries the read address, read data, write
//             address, write data and write response channels.
//  Revision : 1.0  initial release
// ============================================================================
interface axi_lite_master_if;
   // read address channel
   logic [31:0]  readAddr_addr;
   logic         readAddr_valid;
   logic         readAddr_ready;
   // read data channel
   logic [127:0] readData_data;
   logic         readData_valid;
   logic         readData_ready;
   // write address channel
   logic [31:0]  writeAddr_addr;
   logic         writeAddr_valid;
   logic         writeAddr_ready;
   // write data channel
   logic [127:0] writeData_data;
   logic [15:0]  writeData_strb;
   logic         writeData_valid;
   logic         writeData_ready;
   // write response channel
   logic [31:0]  writeResp_msg;
   logic         writeResp_valid;
   logic         writeResp_ready;

   modport master (
      output readAddr_addr, readAddr_valid,
      input  readAddr_ready,
      input  readData_data, readData_valid,
      output readData_ready,
      output writeAddr_addr, writeAddr_valid,
      input  writeAddr_ready,
      output writeData_data, writeData_strb, writeData_valid,
      input  writeData_ready,
      input  writeResp_msg, writeResp_valid,
      output writeResp_ready
   );

   modport slave (
      input  readAddr_addr, readAddr_valid,
      output readAddr_ready,
      output readData_data, readData_valid,
      input  readData_ready,
      input  writeAddr_addr, writeAddr_valid,
      output writeAddr_ready,
      input  writeData_data, writeData_strb, writeData_valid,
      output writeData_ready,
      output writeResp_msg, writeResp_valid,
      input  writeResp_ready
   );
endinterface
`default_nettype wire

// File: rtl/axi_lite_master.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_master
//  Purpose  : Single-outstanding AXI-Lite-style master. It turns one client
//             request into a read or write on the 128-bit channel set. It
//             returns one response and aborts with an error if the slave
//             stalls for TIMEOUT cycles (0 disables the abort).
//  Revision : 1.0  initial release
// ============================================================================
module axi_lite_master #(
   parameter int unsigned TIMEOUT = 255
) (
   input  wire          clk,
   input  wire          rst,
   // client request
   input  wire          req_valid,
   output logic         req_ready,
   input  wire          req_write,
   input  wire  [31:0]  req_addr,
   input  wire  [127:0] req_wdata,
   input  wire  [15:0]  req_strb,
   // client response
   output logic         rsp_valid,
   input  wire          rsp_ready,
   output logic [127:0] rsp_rdata,
   output logic         rsp_err,
   // bus channels
   axi_lite_master_if.master bus
);

   localparam logic [15:0] C_TIMEOUT = 16'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_ADDR = 3'd1,
      S_RD_DATA = 3'd2,
      S_WR_REQ  = 3'd3,
      S_WR_RESP = 3'd4,
      S_RESP    = 3'd5
   } state_t;

   state_t        state_q,   state_d;
   logic [15:0]   cnt_q,     cnt_d;
   logic          aw_done_q, aw_done_d;
   logic          w_done_q,  w_done_d;
   logic [31:0]   rd_addr_q, rd_addr_d;
   logic [31:0]   wr_addr_q, wr_addr_d;
   logic [127:0]  wdata_q,   wdata_d;
   logic [15:0]   strb_q,    strb_d;
   logic [127:0]  rdata_q,   rdata_d;
   logic          err_q,     err_d;

   logic [15:0]   w_cnt_inc;
   logic          w_timeout;
   logic          w_aw_hs;
   logic          w_w_hs;

   // Every output is a decode of registered state, so no input reaches an output combinationally.
   assign req_ready           = (state_q == S_IDLE);
   assign rsp_valid           = (state_q == S_RESP);
   assign rsp_rdata           = rdata_q;
   assign rsp_err             = err_q;
   assign bus.readAddr_addr   = rd_addr_q;
   assign bus.readAddr_valid  = (state_q == S_RD_ADDR);
   assign bus.readData_ready  = (state_q == S_RD_DATA);
   assign bus.writeAddr_addr  = wr_addr_q;
   assign bus.writeAddr_valid = (state_q == S_WR_REQ) && !aw_done_q;
   assign bus.writeData_data  = wdata_q;
   assign bus.writeData_strb  = strb_q;
   assign bus.writeData_valid = (state_q == S_WR_REQ) && !w_done_q;
   assign bus.writeResp_ready = (state_q == S_WR_RESP);

   // The wait counter saturates, so a late state change can never wrap it past the abort threshold.
   assign w_cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
   assign w_timeout = (C_TIMEOUT != 16'd0) && (w_cnt_inc >= C_TIMEOUT);
   assign w_aw_hs   = !aw_done_q && bus.writeAddr_ready;
   assign w_w_hs    = !w_done_q  && bus.writeData_ready;

   // Next-state and holding-register update; a completing handshake is tested before the timeout.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      rd_addr_d = rd_addr_q;
      wr_addr_d = wr_addr_q;
      wdata_d   = wdata_q;
      strb_d    = strb_q;
      rdata_d   = rdata_q;
      err_d     = err_q;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               cnt_d     = 16'd0;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               rdata_d   = '0;
               err_d     = 1'b0;
               // only the channel actually used by this transfer carries the request fields
               rd_addr_d = req_write ? 32'd0 : req_addr;
               wr_addr_d = req_write ? req_addr : 32'd0;
               wdata_d   = req_write ? req_wdata : '0;
               strb_d    = req_write ? req_strb : 16'd0;
               state_d   = req_write ? S_WR_REQ : S_RD_ADDR;
            end
         end

         S_RD_ADDR: begin
            cnt_d = w_cnt_inc;
            if (bus.readAddr_ready) begin
               state_d = S_RD_DATA;
            end else if (w_timeout) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = S_RESP;
            end
         end

         S_RD_DATA: begin
            cnt_d = w_cnt_inc;
            if (bus.readData_valid) begin
               rdata_d = bus.readData_data;
               err_d   = 1'b0;
               state_d = S_RESP;
            end else if (w_timeout) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = S_RESP;
            end
         end

         S_WR_REQ: begin
            cnt_d     = w_cnt_inc;
            aw_done_d = aw_done_q | w_aw_hs;
            w_done_d  = w_done_q  | w_w_hs;
            if (aw_done_d && w_done_d) begin
               state_d = S_WR_RESP;
            end else if (w_timeout) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = S_RESP;
            end
         end

         S_WR_RESP: begin
            cnt_d = w_cnt_inc;
            if (bus.writeResp_valid) begin
               rdata_d = '0;
               err_d   = (bus.writeResp_msg != 32'd0);
               state_d = S_RESP;
            end else if (w_timeout) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = S_RESP;
            end
         end

         S_RESP: begin
            if (rsp_ready) begin
               // drop every held bus value as the master goes idle
               cnt_d     = 16'd0;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               rd_addr_d = 32'd0;
               wr_addr_d = 32'd0;
               wdata_d   = '0;
               strb_d    = 16'd0;
               rdata_d   = '0;
               err_d     = 1'b0;
               state_d   = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and holding registers; reset abandons any in-flight transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= 16'd0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         rd_addr_q <= 32'd0;
         wr_addr_q <= 32'd0;
         wdata_q   <= '0;
         strb_q    <= 16'd0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         rd_addr_q <= rd_addr_d;
         wr_addr_q <= wr_addr_d;
         wdata_q   <= wdata_d;
         strb_q    <= strb_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
      end
   end

endmodule
`default_nettype wire
